// File: rtl/pipeline_exec_controller.sv
// Run/step sequencer for the 5-stage MIPS pipeline driven by the UART debug unit.
// All outputs are decoded from registers; no input reaches an output combinationally.
module pipeline_exec_controller #(
    parameter int CYCLE_CNT_BITS = 16,
    parameter int MAX_CYCLES     = 1024
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [1:0]                i_start_pipeline,
    input  logic                      i_step,
    input  logic                      i_halt_in_wb,
    input  logic                      i_imem_write_en,
    output logic                      o_pipeline_enable,
    output logic                      o_pipeline_reset,
    output logic                      o_program_finished,
    output logic                      o_step_done,
    output logic                      o_timeout,
    output logic [CYCLE_CNT_BITS-1:0] o_cycle_count,
    output logic                      o_busy
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_CLEAR     = 3'd1;
    localparam logic [2:0] S_RUN       = 3'd2;
    localparam logic [2:0] S_STEP_WAIT = 3'd3;
    localparam logic [2:0] S_STEP_EXEC = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;
    localparam logic [2:0] S_FINISHED  = 3'd6;

    localparam logic [CYCLE_CNT_BITS-1:0] WDOG_LAST = CYCLE_CNT_BITS'(MAX_CYCLES - 1);

    logic [2:0]                state;
    logic [2:0]                state_next;
    logic                      step_mode;
    logic                      run_req;
    logic                      wdog_hit;
    logic [CYCLE_CNT_BITS-1:0] cycle_count;
    logic                      timeout;
    logic                      step_done;

    function automatic logic [CYCLE_CNT_BITS-1:0] sat_inc(input logic [CYCLE_CNT_BITS-1:0] v);
        return (v == '1) ? v : v + CYCLE_CNT_BITS'(1);
    endfunction

    // Bit 0 distinguishes an active request (01/11) from idle/abort (00/10).
    assign run_req  = i_start_pipeline[0];
    assign wdog_hit = (cycle_count == WDOG_LAST);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:      if (run_req && !i_imem_write_en) state_next = S_CLEAR;
            S_CLEAR:     state_next = step_mode ? S_STEP_WAIT : S_RUN;
            S_RUN: begin
                if (!run_req)          state_next = S_IDLE;
                else if (i_halt_in_wb) state_next = S_DONE;
                else if (wdog_hit)     state_next = S_DONE;
            end
            S_STEP_WAIT: begin
                if (!run_req)    state_next = S_IDLE;
                else if (i_step) state_next = S_STEP_EXEC;
            end
            S_STEP_EXEC: state_next = i_halt_in_wb ? S_DONE : S_STEP_WAIT;
            S_DONE:      state_next = S_FINISHED;
            S_FINISHED:  if (!run_req) state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= S_IDLE;
            step_mode   <= 1'b0;
            cycle_count <= '0;
            timeout     <= 1'b0;
            step_done   <= 1'b0;
        end else begin
            state     <= state_next;
            step_done <= (state == S_STEP_EXEC) && !i_halt_in_wb;

            if (state == S_IDLE && state_next == S_CLEAR)
                step_mode <= i_start_pipeline[1];

            if (state == S_CLEAR) begin
                cycle_count <= '0;
                timeout     <= 1'b0;
            end else if (state == S_RUN || state == S_STEP_EXEC) begin
                cycle_count <= sat_inc(cycle_count);
            end

            // Halt outranks the watchdog, and an abort ends the run silently.
            if (state == S_RUN && run_req && !i_halt_in_wb && wdog_hit)
                timeout <= 1'b1;
        end
    end

    assign o_pipeline_enable  = (state == S_RUN) || (state == S_STEP_EXEC);
    assign o_pipeline_reset   = (state == S_CLEAR);
    assign o_program_finished = (state == S_DONE);
    assign o_busy             = (state != S_IDLE);
    assign o_step_done        = step_done;
    assign o_timeout          = timeout;
    assign o_cycle_count      = cycle_count;

endmodule

// File: doc/pipeline_exec_controller.md
# pipeline_exec_controller

Sequences execution of the 5-stage MIPS pipeline on behalf of the UART debug unit. Converts the 2-bit run request (continuous or stepwise) into a single clock-enable for the PC and all inter-stage latches. Detects program completion (HALT retired in WB) or a watchdog timeout, counts executed cycles, and signals completion back to the debug unit.

## Interface
- `CYCLE_CNT_BITS`, default 16: width of the executed-cycle counter.
- `MAX_CYCLES`, default 1024: watchdog limit in enabled cycles; must satisfy 1 ≤ MAX_CYCLES ≤ 2^CYCLE_CNT_BITS.

Ports:
- `i_clk`  in  1  clock.
- `i_reset`  in  1  reset, asynchronous, active-high.
- `i_start_pipeline`  in  2  run request from debug unit.
  - 00 = idle/abort, 01 = continuous, 11 = stepwise, 10 = treated as 00.
- `i_step`  in  1  single-cycle pulse: execute one pipeline cycle (stepwise mode only).
- `i_halt_in_wb`  in  1  HALT opcode present in MEM/WB this cycle.
- `i_imem_write_en`  in  1  instruction memory is being programmed; blocks starting a run.
- `o_pipeline_enable`  out  1  clock-enable for PC and IF/ID, ID/EX, EX/MEM, MEM/WB.
- `o_pipeline_reset`  out  1  one-cycle synchronous clear of PC and latches at run start.
- `o_program_finished`  out  1  one-cycle completion pulse to debug unit.
- `o_step_done`  out  1  one-cycle pulse after each executed step.
- `o_timeout`  out  1  sticky: last run ended by watchdog.
- `o_cycle_count`  out  CYCLE_CNT_BITS  enabled cycles in current/last run.
- `o_busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, CLEAR, RUN, STEP_WAIT, STEP_EXEC, DONE, FINISHED.
- IDLE:
  - If `i_start_pipeline` ∈ {01, 11} and `i_imem_write_en`=0: latch mode, go to CLEAR.
  - Otherwise stay.
- CLEAR:
  - `o_pipeline_reset`=1.
  - `o_cycle_count`<=0, `o_timeout`<=0.
  - Next state: RUN for mode 01, STEP_WAIT for mode 11.
- RUN:
  - Each cycle `o_cycle_count`++.
  - Priority, evaluated in order:
    1. abort (`i_start_pipeline`=00/10): go to IDLE, no finished pulse.
    2. `i_halt_in_wb`: go to DONE.
    3. count == MAX_CYCLES-1: go to DONE and set `o_timeout`.
- STEP_WAIT:
  - Abort: go to IDLE.
  - `i_step`: go to STEP_EXEC.
- STEP_EXEC:
  - Exactly one enabled cycle; count++.
  - `i_halt_in_wb`: go to DONE.
  - Else: go to STEP_WAIT and pulse `o_step_done` in the first STEP_WAIT cycle.
- DONE:
  - `o_program_finished`=1 for exactly one cycle.
  - Go to FINISHED.
- FINISHED:
  - Hold until `i_start_pipeline`=00, then go to IDLE.
  - Prevents auto-restart while the debug unit still holds its run flag.
- Mode is latched at IDLE→CLEAR; mode changes between 01 and 11 mid-run are ignored.
- `i_step` is ignored outside STEP_WAIT, including a pulse arriving during STEP_EXEC.
- `i_imem_write_en` is only checked in IDLE.
- `i_halt_in_wb` is qualified only in RUN/STEP_EXEC; it is ignored when the enable is low.
- Halt and watchdog in the same cycle: halt wins, `o_timeout` stays 0.
- `o_cycle_count` saturates at all-ones and holds its value after DONE until the next CLEAR.

## Timing
- Reset (async) values:
  - state=IDLE.
  - `o_pipeline_enable`, `o_pipeline_reset`, `o_program_finished`, `o_step_done`, `o_timeout`, `o_busy` = 0.
  - `o_cycle_count`=0.
- `o_pipeline_enable` is decoded from the state register only: 1 exactly in RUN and STEP_EXEC.
  - There is no combinational path from any input to any output.
- Start latency: request sampled in IDLE at edge N; CLEAR during cycle N+1; first enabled cycle N+2.
- Halt latency: `i_halt_in_wb` sampled high at edge M; the enable drops in cycle M+1, which is the DONE cycle with `o_program_finished`=1.
  - The cycle in which the halt was seen is counted.
- Step: `i_step` sampled at edge K; enable high during cycle K+1 only; `o_step_done` high during cycle K+2.
- Reset mid-run: enable drops immediately (asynchronously); no finished pulse.

## Test plan
- Continuous run, HALT in WB on 12th enabled cycle:
  - `o_pipeline_reset` pulses once.
  - Enable high for 12 cycles.
  - `o_program_finished` pulses once; `o_cycle_count`=12, `o_timeout`=0.
  - Stays in FINISHED until `i_start_pipeline`=00.
- Stepwise mode, 3 `i_step` pulses spaced 5 cycles apart:
  - Exactly 3 single enable cycles, 3 `o_step_done` pulses, count=3.
  - A 4th pulse issued during STEP_EXEC is ignored.
- Watchdog with MAX_CYCLES=8, no halt:
  - Enable high for 8 cycles; finished pulse; `o_timeout`=1; count=8.
  - Halt on cycle 8 instead: `o_timeout`=0.
- Start requested with `i_imem_write_en`=1: remains in IDLE with enable 0; starts 2 cycles after write_en falls.
- Abort: `i_start_pipeline`→00 during RUN after 5 cycles.
  - Go to IDLE, no finished pulse, count=5.
  - A new start clears the count to 0.
- Async reset asserted mid-RUN: all outputs 0 immediately; state IDLE after release.
